multicycle_mem: RTL and testbench

Multi-cycle, word-organised 16-bit data memory that answers load/store requests issued by the CPU memory stage. It replaces the single-cycle data memory on the responder side of the request/response interface. Each accepted request completes a fixed LATENCY cycles later with a one-cycle response pulse. It holds one request in flight at a time, and back-pressures the CPU through `req_ready`.

---
 rtl/multicycle_mem_if.sv | 25 ++
 rtl/multicycle_mem.sv | 128 ++++++++++++
 tb/tb_multicycle_mem.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_mem_if : CPU data-memory request/response bus              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface multicycle_mem_if;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_mem : fixed-latency 16-bit word data memory, one request   |
// | in flight, response pulse LATENCY cycles after accept.  Rev 1.0       |
// +----------------------------------------------------------------------+
module multicycle_mem #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 15
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  multicycle_mem_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] C_CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam int         C_WORDS    = 1 << DEPTH_LOG2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic                  r_wr;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [15:0]           r_wdata;
  logic [15:0]           r_rdata;
  logic [15:0]           r_mem [0:C_WORDS-1];

  logic                  w_ready;
  logic                  w_rsp_valid;
  logic                  w_accept;
  logic                  w_enter_done;
  logic                  w_op_wr;
  logic [DEPTH_LOG2-1:0] w_op_idx;
  logic [15:0]           w_op_wdata;
  logic                  w_unused_addr;

  assign w_accept     = bus.req_valid & w_ready;
  assign w_enter_done = (w_state_next == S_DONE);

  // With LATENCY=1 the array is accessed on the accept edge itself, so the
  // live request fields are used instead of the not-yet-loaded latches.
  assign w_op_wr    = (LATENCY == 1) ? bus.req_wr : r_wr;
  assign w_op_idx   = (LATENCY == 1) ? bus.req_addr[DEPTH_LOG2:1] : r_idx;
  assign w_op_wdata = (LATENCY == 1) ? bus.req_wdata : r_wdata;

  // Bit 0 and bits above the word index are don't-care address bits.
  assign w_unused_addr = bus.req_addr[0] ^ (|(bus.req_addr >> (DEPTH_LOG2 + 1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_next = (LATENCY == 1) ? S_DONE : S_WAIT;
          w_cnt_next   = C_CNT_INIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready     = 1'b1;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_WAIT:  w_ready     = 1'b0;
      S_DONE:  w_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 16'd0;
      r_rdata <= 16'd0;
    end else begin
      if (w_accept) begin
        r_wr    <= bus.req_wr;
        r_idx   <= bus.req_addr[DEPTH_LOG2:1];
        r_wdata <= bus.req_wdata;
      end
      if (w_enter_done && !w_op_wr) begin
        r_rdata <= r_mem[w_op_idx];
      end else begin
        r_rdata <= 16'd0;
      end
    end
  end

  // Array contents survive reset; a reset on the DONE edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && w_enter_done && w_op_wr) begin
      r_mem[w_op_idx] <= w_op_wdata;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_mem : random + directed bench for three builds          |
// | (L=4/D=15, L=4/D=4, L=1/D=15) against a cycle-level reference. Rev 1.0|
// +----------------------------------------------------------------------+
module tb_multicycle_mem;

  logic clk;
  logic rst_n;

  logic [2:0]  dv;
  logic [2:0]  dwr;
  logic [15:0] da [3];
  logic [15:0] dd [3];
  logic [2:0]  rdy;
  logic [2:0]  rv;
  logic [15:0] rd [3];

  multicycle_mem_if bus0 ();
  multicycle_mem_if bus1 ();
  multicycle_mem_if bus2 ();

  multicycle_mem #(.LATENCY(4), .DEPTH_LOG2(15)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  multicycle_mem #(.LATENCY(4), .DEPTH_LOG2(4))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  multicycle_mem #(.LATENCY(1), .DEPTH_LOG2(15)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.req_valid = dv[0];  assign bus0.req_wr = dwr[0];
  assign bus0.req_addr  = da[0];  assign bus0.req_wdata = dd[0];
  assign bus1.req_valid = dv[1];  assign bus1.req_wr = dwr[1];
  assign bus1.req_addr  = da[1];  assign bus1.req_wdata = dd[1];
  assign bus2.req_valid = dv[2];  assign bus2.req_wr = dwr[2];
  assign bus2.req_addr  = da[2];  assign bus2.req_wdata = dd[2];
  assign rdy = {bus2.req_ready, bus1.req_ready, bus0.req_ready};
  assign rv  = {bus2.rsp_valid, bus1.rsp_valid, bus0.rsp_valid};
  assign rd[0] = bus0.rsp_rdata;
  assign rd[1] = bus1.rsp_rdata;
  assign rd[2] = bus2.rsp_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: each accepted request is due exactly LAT cycles later; memory
  // is a plain array updated when a store's response cycle is reached.
  int          lat [3] = '{4, 4, 1};
  int          dep [3] = '{15, 4, 15};
  int          cyc = 0;
  bit          inited = 1'b0;
  bit          pend [3];
  int          due  [3];
  bit          pwr  [3];
  int          pidx [3];
  logic [15:0] pwd  [3];
  logic [15:0] mmem  [3][32768];
  bit          known [3][32768];

  initial begin
    for (int k = 0; k < 3; k++) pend[k] = 1'b0;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : model
    bit          ev, er, dchk;
    logic [15:0] ed;
    for (int k = 0; k < 3; k++) begin
      ev   = pend[k] && (due[k] == cyc);
      er   = !pend[k] || ev;
      ed   = 16'd0;
      dchk = 1'b1;
      if (ev && !pwr[k]) begin
        if (known[k][pidx[k]]) ed = mmem[k][pidx[k]];
        else dchk = 1'b0;
      end
      if (ev && pwr[k]) begin
        mmem[k][pidx[k]]  = pwd[k];
        known[k][pidx[k]] = 1'b1;
      end
      if (inited) begin
        check_val($sformatf("u%0d.req_ready", k), {15'd0, rdy[k]}, {15'd0, er});
        check_val($sformatf("u%0d.rsp_valid", k), {15'd0, rv[k]}, {15'd0, ev});
        if (dchk) check_val($sformatf("u%0d.rsp_rdata", k), rd[k], ed);
      end
      if (!rst_n) begin
        pend[k] = 1'b0;
      end else if (dv[k] && er) begin
        pend[k] = 1'b1;
        due[k]  = cyc + lat[k];
        pwr[k]  = dwr[k];
        pidx[k] = (int'(da[k]) >> 1) & ((1 << dep[k]) - 1);
        pwd[k]  = dd[k];
      end else if (ev) begin
        pend[k] = 1'b0;
      end
    end
    if (!rst_n) inited = 1'b1;
  end

  // Present a request and hold it until the edge that accepts it.
  task automatic issue(input int k, input bit wr, input logic [15:0] a, input logic [15:0] d);
    bit got;
    got    = 1'b0;
    dv[k]  = 1'b1;
    dwr[k] = wr;
    da[k]  = a;
    dd[k]  = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = rdy[k];
      @(posedge clk);
      #1;
    end
    if (!got) check_val($sformatf("u%0d.accept_timeout", k), 16'd0, 16'd1);
    dv[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_random(input int k, input int n);
    bit          wr;
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      wr = 1'(($urandom_range(0, 2) != 0) ? 1 : 0);
      a  = 16'(($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
      if (k == 1) a = a | (16'($urandom) & 16'hFFE0);
      issue(k, wr, a, 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) begin
        idle($urandom_range(0, lat[k]));
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dv    = 3'b111;
    dwr   = 3'b000;
    for (int k = 0; k < 3; k++) begin
      da[k] = 16'h0010;
      dd[k] = 16'h0000;
    end
    idle(2);
    rst_n = 1'b1;
    dv    = 3'b000;
    idle(2);

    // Store/load round trip, then continuous back-pressured loads.
    issue(0, 1'b1, 16'h0010, 16'hBEEF);
    issue(0, 1'b0, 16'h0010, 16'h0000);
    for (int i = 0; i < 6; i++) issue(0, 1'b0, 16'h0020, 16'h0000);
    idle(5);

    // Bit 0 is ignored; small build wraps above the word index.
    issue(0, 1'b1, 16'h0021, 16'h1234);
    issue(0, 1'b0, 16'h0020, 16'h0000);
    issue(1, 1'b1, 16'h0002, 16'h5555);
    issue(1, 1'b0, 16'h0022, 16'h0000);
    idle(5);

    // Store abandoned by reset two cycles after accept.
    issue(0, 1'b1, 16'h0040, 16'h1111);
    issue(0, 1'b1, 16'h0040, 16'hAAAA);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    issue(0, 1'b0, 16'h0040, 16'h0000);
    idle(5);

    // Single-cycle build: alternate store/load every cycle.
    for (int i = 1; i <= 6; i++) begin
      issue(2, 1'b1, 16'h0004, 16'(i));
      issue(2, 1'b0, 16'h0004, 16'h0000);
    end
    idle(3);

    for (int k = 0; k < 3; k++) begin
      run_random(k, 60);
      idle(6);
    end

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
